// File: rtl/fetch_sequencer_pkg.sv
// Shared encodings and defaults for the fetch sequencer.
// Interrupt states exist only when FETCH_SEQ_INT_EN is defined.
package fetch_seq_pkg;

  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0020;
  localparam logic [31:0] INT_VEC_DEF   = 32'h0000_0000;
  localparam int          CNT_W         = 3;

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_RUN   = 3'd1,
    S_IMM   = 3'd2
`ifdef FETCH_SEQ_INT_EN
    ,
    S_DRAIN = 3'd3,
    S_SAVE  = 3'd4,
    S_VEC   = 3'd5
`endif
  } state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between the fetch sequencer (master) and the fetch datapath (slave).
interface fetch_sequencer_if;

  logic        stall;
  logic        jumpBit;
  logic [31:0] jumpTarget;
  logic        intReq;
  logic        twoWord;
  logic [31:0] curPc;
  logic [31:0] pcNext;
  logic        pcLoad;
  logic        bubble;
  logic        intAck;
  logic [31:0] retPc;
  logic        retPcValid;
  logic [2:0]  seqState;

  modport master (
    input  stall, jumpBit, jumpTarget, intReq, twoWord, curPc,
    output pcNext, pcLoad, bubble, intAck, retPc, retPcValid, seqState
  );

  modport slave (
    output stall, jumpBit, jumpTarget, intReq, twoWord, curPc,
    input  pcNext, pcLoad, bubble, intAck, retPc, retPcValid, seqState
  );

endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-stage control FSM: PC source select, bubble insertion and interrupt entry.
// Define FETCH_SEQ_INT_EN to compile in the interrupt path (DRAIN/SAVE/VEC, retPc).
import fetch_seq_pkg::*;

module fetch_sequencer #(
  parameter logic [31:0] RESET_VEC        = RESET_VEC_DEF,
  parameter logic [31:0] INT_VEC          = INT_VEC_DEF,
  parameter int          INT_DRAIN_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  fetch_sequencer_if.master bus
);

  state_t      state_q, state_d;
  logic [31:0] pc_next;
  logic        pc_load;
  logic        bubble;
  logic        int_ack;
  logic        ret_valid;

`ifdef FETCH_SEQ_INT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      ret_q, ret_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RESET;
`ifdef FETCH_SEQ_INT_EN
      cnt_q   <= '0;
      ret_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef FETCH_SEQ_INT_EN
      cnt_q   <= cnt_d;
      ret_q   <= ret_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_next   = bus.curPc;
    pc_load   = 1'b0;
    bubble    = 1'b0;
    int_ack   = 1'b0;
    ret_valid = 1'b0;
`ifdef FETCH_SEQ_INT_EN
    cnt_d     = cnt_q;
    ret_d     = ret_q;
`endif
    case (state_q)
      S_RESET: begin
        pc_next = RESET_VEC;
        pc_load = 1'b1;
        bubble  = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.jumpBit) begin
          pc_next = bus.jumpTarget;
          pc_load = 1'b1;
          bubble  = 1'b1;
        end else if (!bus.stall) begin
`ifdef FETCH_SEQ_INT_EN
          if (bus.intReq) begin
            bubble  = 1'b1;
            ret_d   = bus.curPc;
            cnt_d   = CNT_W'(INT_DRAIN_CYCLES - 1);
            state_d = S_DRAIN;
          end else begin
`else
          begin
`endif
            pc_next = bus.curPc + 32'd1;
            pc_load = 1'b1;
            if (bus.twoWord) state_d = S_IMM;
          end
        end
      end
      // Immediate word is never split from its opcode, so interrupts wait here.
      S_IMM: begin
        if (bus.jumpBit) begin
          pc_next = bus.jumpTarget;
          pc_load = 1'b1;
          bubble  = 1'b1;
          state_d = S_RUN;
        end else if (!bus.stall) begin
          pc_next = bus.curPc + 32'd1;
          pc_load = 1'b1;
          state_d = S_RUN;
        end
      end
`ifdef FETCH_SEQ_INT_EN
      // A jump resolving while draining redirects where the handler returns to.
      S_DRAIN: begin
        bubble = 1'b1;
        if (bus.jumpBit) ret_d = bus.jumpTarget;
        if (!bus.stall) begin
          if (cnt_q == '0) state_d = S_SAVE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      S_SAVE: begin
        bubble    = 1'b1;
        ret_valid = 1'b1;
        if (!bus.stall) state_d = S_VEC;
      end
      S_VEC: begin
        pc_next = INT_VEC;
        pc_load = 1'b1;
        bubble  = 1'b1;
        int_ack = 1'b1;
        state_d = S_RUN;
      end
`endif
      default: state_d = S_RESET;
    endcase
    // Reset masks everything so an aborted entry never acknowledges or saves.
    if (rst) begin
      pc_next   = RESET_VEC;
      pc_load   = 1'b1;
      bubble    = 1'b1;
      int_ack   = 1'b0;
      ret_valid = 1'b0;
    end
  end

  assign bus.pcNext     = pc_next;
  assign bus.pcLoad     = pc_load;
  assign bus.bubble     = bubble;
  assign bus.intAck     = int_ack;
  assign bus.retPcValid = ret_valid;
  assign bus.seqState   = rst ? 3'd0 : state_q;

`ifdef FETCH_SEQ_INT_EN
  assign bus.retPc = ret_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{bus.intReq, INT_VEC, CNT_W'(INT_DRAIN_CYCLES)};
  assign bus.retPc  = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed vectors push expectations, a monitor checks each cycle.
// Expectations follow FETCH_SEQ_INT_EN so either build is checked.
module tb_fetch_sequencer;

  typedef struct packed {
    logic [15:0] idx;
    logic [31:0] pc;
    logic        pchk;
    logic        ld;
    logic        bub;
    logic        ack;
    logic        rv;
    logic [31:0] ret;
    logic        rchk;
    logic [2:0]  st;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  fetch_sequencer_if bus();

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   vec_n  = 0;

  fetch_sequencer #(
    .RESET_VEC        (32'h0000_0020),
    .INT_VEC          (32'h0000_0000),
    .INT_DRAIN_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t ex(logic [31:0] pc, int pchk, int ld, int bub, int ack,
                              int rv, logic [31:0] ret, int rchk, int st);
    exp_t e;
    e.idx  = '0;
    e.pc   = pc;
    e.pchk = (pchk != 0);
    e.ld   = (ld != 0);
    e.bub  = (bub != 0);
    e.ack  = (ack != 0);
    e.rv   = (rv != 0);
    e.ret  = ret;
    e.rchk = (rchk != 0);
    e.st   = 3'(st);
    return e;
  endfunction

  // Inputs change 1ns after the edge; the matching expectation enters the queue with them.
  task automatic applyStimulus(input int r, input int s, input int j, input logic [31:0] jt,
                               input int i, input int w, input logic [31:0] cp, input exp_t e);
    @(posedge clk);
    #1;
    rst            = (r != 0);
    bus.stall      = (s != 0);
    bus.jumpBit    = (j != 0);
    bus.jumpTarget = jt;
    bus.intReq     = (i != 0);
    bus.twoWord    = (w != 0);
    bus.curPc      = cp;
    e.idx          = 16'(vec_n);
    vec_n++;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [15:0] idx, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s vec %0d: got %h required %h", nm, idx, act, req);
  endtask

  task automatic checkOutput(input exp_t e);
    if (e.pchk) chk("pcNext", e.idx, bus.pcNext, e.pc);
    chk("pcLoad",     e.idx, 32'(bus.pcLoad),     32'(e.ld));
    chk("bubble",     e.idx, 32'(bus.bubble),     32'(e.bub));
    chk("intAck",     e.idx, 32'(bus.intAck),     32'(e.ack));
    chk("retPcValid", e.idx, 32'(bus.retPcValid), 32'(e.rv));
    if (e.rchk) chk("retPc", e.idx, bus.retPc, e.ret);
    chk("seqState",   e.idx, 32'(bus.seqState),   32'(e.st));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin : stimulus
    bus.stall = 1'b0; bus.jumpBit = 1'b0; bus.jumpTarget = '0;
    bus.intReq = 1'b0; bus.twoWord = 1'b0; bus.curPc = '0;

    // reset held, then release: RESET drives the reset vector once
    applyStimulus(1,0,0,0,0,0,32'h0,        ex(32'h20,1,1,1,0,0,0,1,0));
    applyStimulus(1,0,0,0,1,0,32'h5,        ex(32'h20,1,1,1,0,0,0,1,0));
    applyStimulus(0,0,0,0,0,0,32'h0,        ex(32'h20,1,1,1,0,0,0,1,0));
    applyStimulus(0,0,0,0,0,0,32'h20,       ex(32'h21,1,1,0,0,0,0,1,1));
    applyStimulus(0,0,0,0,0,0,32'h21,       ex(32'h22,1,1,0,0,0,0,1,1));
    applyStimulus(0,0,0,0,0,0,32'hFFFF_FFFF,ex(32'h0,1,1,0,0,0,0,1,1));
    applyStimulus(0,1,0,0,0,0,32'h55,       ex(32'h55,1,0,0,0,0,0,1,1));
    // IMM: stall holds, jump overrides back to RUN
    applyStimulus(0,0,0,0,0,1,32'h30,       ex(32'h31,1,1,0,0,0,0,1,1));
    applyStimulus(0,1,0,0,0,0,32'h31,       ex(32'h31,1,0,0,0,0,0,1,2));
    applyStimulus(0,0,1,32'h300,0,0,32'h31, ex(32'h300,1,1,1,0,0,0,1,2));
    applyStimulus(0,0,0,0,0,0,32'h300,      ex(32'h301,1,1,0,0,0,0,1,1));
    // jump wins over a simultaneous interrupt request
    applyStimulus(0,0,1,32'h100,1,0,32'h56, ex(32'h100,1,1,1,0,0,0,1,1));
`ifdef FETCH_SEQ_INT_EN
    applyStimulus(0,0,0,0,1,0,32'h100,      ex(0,0,0,1,0,0,0,1,1));
    applyStimulus(0,0,0,0,1,0,32'h100,      ex(0,0,0,1,0,0,32'h100,1,3));
    applyStimulus(0,0,0,0,1,0,32'h100,      ex(0,0,0,1,0,0,32'h100,1,3));
    applyStimulus(0,0,0,0,1,0,32'h100,      ex(0,0,0,1,0,1,32'h100,1,4));
    applyStimulus(0,0,0,0,1,0,32'h100,      ex(32'h0,1,1,1,1,0,32'h100,1,5));
    applyStimulus(0,0,0,0,0,0,32'h0,        ex(32'h1,1,1,0,0,0,32'h100,1,1));
    // plain entry from curPc=0x40: intAck four cycles after acceptance
    applyStimulus(0,0,0,0,1,0,32'h40,       ex(0,0,0,1,0,0,0,0,1));
    applyStimulus(0,0,0,0,1,0,32'h40,       ex(0,0,0,1,0,0,32'h40,1,3));
    applyStimulus(0,0,0,0,1,0,32'h40,       ex(0,0,0,1,0,0,32'h40,1,3));
    applyStimulus(0,0,0,0,1,0,32'h40,       ex(0,0,0,1,0,1,32'h40,1,4));
    applyStimulus(0,0,0,0,1,0,32'h40,       ex(32'h0,1,1,1,1,0,0,0,5));
    applyStimulus(0,0,0,0,0,0,32'h0,        ex(32'h1,1,1,0,0,0,0,0,1));
    // stalls in DRAIN stretch entry; intReq dropping after acceptance does not cancel
    applyStimulus(0,0,0,0,1,0,32'h40,       ex(0,0,0,1,0,0,0,0,1));
    applyStimulus(0,0,0,0,0,0,32'h40,       ex(0,0,0,1,0,0,32'h40,1,3));
    applyStimulus(0,1,0,0,0,0,32'h40,       ex(0,0,0,1,0,0,32'h40,1,3));
    applyStimulus(0,1,0,0,0,0,32'h40,       ex(0,0,0,1,0,0,32'h40,1,3));
    applyStimulus(0,0,0,0,0,0,32'h40,       ex(0,0,0,1,0,0,32'h40,1,3));
    applyStimulus(0,0,0,0,0,0,32'h40,       ex(0,0,0,1,0,1,32'h40,1,4));
    applyStimulus(0,0,0,0,0,0,32'h40,       ex(32'h0,1,1,1,1,0,0,0,5));
    // jump during DRAIN retargets retPc; stall in SAVE keeps retPcValid high
    applyStimulus(0,0,0,0,1,0,32'h80,       ex(0,0,0,1,0,0,0,0,1));
    applyStimulus(0,0,1,32'h200,1,0,32'h80, ex(0,0,0,1,0,0,32'h80,1,3));
    applyStimulus(0,0,0,0,1,0,32'h80,       ex(0,0,0,1,0,0,32'h200,1,3));
    applyStimulus(0,1,0,0,1,0,32'h80,       ex(0,0,0,1,0,1,32'h200,1,4));
    applyStimulus(0,0,0,0,1,0,32'h80,       ex(0,0,0,1,0,1,32'h200,1,4));
    applyStimulus(0,0,0,0,1,0,32'h80,       ex(32'h0,1,1,1,1,0,0,0,5));
    // twoWord then intReq: IMM ignores it, RUN accepts next; reset aborts in DRAIN
    applyStimulus(0,0,0,0,0,1,32'h10,       ex(32'h11,1,1,0,0,0,0,0,1));
    applyStimulus(0,0,0,0,1,0,32'h11,       ex(32'h12,1,1,0,0,0,0,0,2));
    applyStimulus(0,0,0,0,1,0,32'h12,       ex(0,0,0,1,0,0,0,0,1));
    applyStimulus(1,0,0,0,1,0,32'h12,       ex(32'h20,1,1,1,0,0,0,0,0));
    applyStimulus(0,0,0,0,0,0,32'h12,       ex(32'h20,1,1,1,0,0,0,1,0));
    applyStimulus(0,0,0,0,0,0,32'h20,       ex(32'h21,1,1,0,0,0,0,1,1));
    applyStimulus(0,0,0,0,0,0,32'h21,       ex(32'h22,1,1,0,0,0,0,1,1));
`else
    // interrupts compiled out: intReq has no effect, retPc stays 0
    applyStimulus(0,0,0,0,1,0,32'h100,      ex(32'h101,1,1,0,0,0,0,1,1));
    applyStimulus(0,0,0,0,1,1,32'h101,      ex(32'h102,1,1,0,0,0,0,1,1));
    applyStimulus(0,0,0,0,1,0,32'h102,      ex(32'h103,1,1,0,0,0,0,1,2));
    applyStimulus(0,0,0,0,1,0,32'h103,      ex(32'h104,1,1,0,0,0,0,1,1));
    applyStimulus(0,0,0,0,1,0,32'h104,      ex(32'h105,1,1,0,0,0,0,1,1));
`endif

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("[TB] FAIL drain: got %0d pending required 0", exp_q.size());
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Control FSM for the fetch stage. Each cycle it selects the PC source (reset vector, sequential, jump target, interrupt vector) and drives the PC load enable. It also inserts bubbles into the fetch/decode register and sequences interrupt entry: drain, return-address save, vector load. It sits beside the fetch datapath and feeds the PC register.

## Interface
Parameters:
- RESET_VEC, 32'h0000_0020, PC loaded after reset
- INT_VEC, 32'h0000_0000, PC loaded on interrupt entry
- INT_DRAIN_CYCLES, 2, bubble cycles before return-address save (1..7)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- stall  in  1  hazard stall from downstream stages
- jumpBit  in  1  resolved taken jump/branch this cycle
- jumpTarget  in  32  jump destination, valid with jumpBit
- intReq  in  1  level interrupt request, held until intAck
- twoWord  in  1  instruction currently fetched carries an immediate word
- curPc  in  32  PC register value
- pcNext  out  32  value for PC register
- pcLoad  out  1  PC register enable
- bubble  out  1  replace fetched word with NOP
- intAck  out  1  one-cycle interrupt acknowledge
- retPc  out  32  latched return address
- retPcValid  out  1  one-cycle request to push retPc
- seqState  out  3  current state, debug

## Operation
- States: RESET, RUN, IMM, DRAIN, SAVE, VEC. Outputs are Mealy, derived from state and inputs.
- RESET: pcNext=RESET_VEC, pcLoad=1, bubble=1. Exits to RUN on the first cycle with rst=0.
- RUN, priority order:
  - jumpBit: pcNext=jumpTarget, pcLoad=1, bubble=1. Stays RUN. An intReq in the same cycle is deferred one cycle.
  - stall: pcLoad=0, pcNext=curPc, bubble=0. An intReq during stall is deferred.
  - intReq: pcLoad=0, bubble=1, retPc<=curPc, counter<=INT_DRAIN_CYCLES-1, go DRAIN.
  - twoWord: pcNext=curPc+1, pcLoad=1, go IMM.
  - else: pcNext=curPc+1, pcLoad=1.
- IMM (immediate fetch): pcNext=curPc+1, pcLoad=1, go RUN.
  - intReq is ignored in IMM.
  - jumpBit overrides (as in RUN) and goes to RUN.
  - stall holds in IMM.
- DRAIN: pcLoad=0, bubble=1.
  - stall freezes the counter.
  - jumpBit updates retPc<=jumpTarget and loads no PC.
  - Counter at 0 and no stall: go SAVE.
- SAVE: retPcValid=1, bubble=1, pcLoad=0. stall holds in SAVE with retPcValid kept high. Otherwise go VEC.
- VEC: pcNext=INT_VEC, pcLoad=1, bubble=1, intAck=1, go RUN.
- Arithmetic: curPc+1 is 32-bit modulo; 32'hFFFF_FFFF wraps to 0.
- rst in any state forces RESET on the next edge and aborts an interrupt in progress. intAck and retPcValid never assert for an aborted entry.

## Timing
- Reset values: state RESET, counter 0, retPc 0. While rst=1, outputs are pcNext=RESET_VEC, pcLoad=1, bubble=1, intAck=0, retPcValid=0, seqState=0.
- Jump: pcNext=jumpTarget in the same cycle as jumpBit (zero-cycle combinational); new PC visible next cycle.
- Interrupt latency with no stalls: intReq accepted in RUN at cycle t.
  - DRAIN occupies t+1 .. t+INT_DRAIN_CYCLES.
  - SAVE at t+INT_DRAIN_CYCLES+1.
  - VEC/intAck at t+INT_DRAIN_CYCLES+2.
  - Default: intAck at t+4.
- Each stall cycle in DRAIN or SAVE adds one cycle.
- intReq must stay high until intAck. Deasserting it after acceptance does not cancel the entry.

## Configuration
- FETCH_SEQ_INT_EN defined: interrupt path (DRAIN/SAVE/VEC, retPc, INT_VEC) compiled in.
- Undefined:
  - intReq is ignored.
  - intAck, retPcValid and retPc are tied to 0.
  - DRAIN/SAVE/VEC are absent; the FSM has only RESET, RUN, IMM.

## Structure
- Shared package fetch_seq_pkg:
  - state encoding: RESET=0, RUN=1, IMM=2, DRAIN=3, SAVE=4, VEC=5
  - default RESET_VEC/INT_VEC constants
  - counter width (3)
- No sub-module. State register, drain counter and output decode stay in one module.

## Test plan
- Release rst at cycle 0, no inputs -> cycle 0: pcNext=32'h20, bubble=1. Then pcNext=curPc+1 each cycle.
- jumpBit=1, jumpTarget=32'h100, with intReq=1 in the same RUN cycle -> pcNext=32'h100, bubble=1. Interrupt accepted next cycle with retPc=32'h100.
- intReq at t, curPc=32'h40, no stalls -> bubble t..t+4. retPcValid=1, retPc=32'h40 at t+3. intAck=1, pcNext=0 at t+4.
- Same as previous with stall high at t+2 and t+3 -> retPcValid at t+5, intAck at t+6.
- twoWord=1 with intReq=1 -> IMM cycle loads curPc+1 and ignores intReq. Interrupt accepted the following cycle.
- rst asserted during DRAIN -> next cycle in RESET, pcNext=32'h20. intAck and retPcValid never assert. curPc=32'hFFFF_FFFF in RUN -> pcNext=0.
